// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field positions and the PE control state.
package noc_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_e;

  // Flit layout, MSB first: valid, single-flit marker, dest, tag/VC, payload.
  function automatic int flit_w(input int data_w, input int dest_w);
    return data_w + dest_w + 3;
  endfunction

  function automatic int valid_bit(input int data_w, input int dest_w);
    return flit_w(data_w, dest_w) - 1;
  endfunction

  function automatic int mark_bit(input int data_w, input int dest_w);
    return flit_w(data_w, dest_w) - 2;
  endfunction

  function automatic int dest_lsb(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int vc_bit(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/xor_operand_collector.sv
// Operand staging for the XOR PE: holds A/B and their have-flags, and strobes
// pair_done with the XOR result on the edge that completes an operand set.
module xor_operand_collector
  import noc_pkg::*;
#(
  parameter int                DATA_W = 64,
  parameter int                MODE   = 0,
  parameter logic [DATA_W-1:0] KEY    = DATA_W'(4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              tag,
  input  logic [DATA_W-1:0] data,
  output logic              pair_done,
  output logic [DATA_W-1:0] pair_result
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              have_a;
  logic              have_b;
  logic              load_a;
  logic              load_b;

  assign load_a = load & ~tag;
  assign load_b = load & tag;

  // Completion looks at the incoming operand directly so the pair fires on the
  // same edge that delivers the second half.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block leaves a latch.
    pair_done   = 1'b0;
    pair_result = '0;
    if (MODE == 0) begin
      pair_done   = load_a;
      pair_result = data ^ KEY;
    end else begin
      pair_done   = (load_a & have_b) | (load_b & have_a);
      pair_result = load_a ? (data ^ op_b) : (op_a ^ data);
    end
  end

  // NOTE: the operand registers are reset too, so a partial pair never survives rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      have_a <= 1'b0;
      have_b <= 1'b0;
    end else if (pair_done) begin
      have_a <= 1'b0;
      have_b <= 1'b0;
    end else begin
      if (load_a) begin
        op_a   <= data;
        have_a <= 1'b1;
      end
      if (load_b) begin
        op_b   <= data;
        have_b <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/xor_pe_mcast.sv
// XOR processing element behind a router local port: collects operands, XORs
// them, and multicasts the result flit to every entry of DEST_LIST in order.
module xor_pe_mcast
  import noc_pkg::*;
#(
  parameter int                         DATA_W    = 64,
  parameter int                         DEST_W    = 4,
  parameter int                         NUM_DEST  = 2,
  parameter int                         MODE      = 0,
  parameter logic [DATA_W-1:0]          KEY       = DATA_W'(4),
  parameter logic [NUM_DEST*DEST_W-1:0] DEST_LIST = {4'b0111, 4'b0111},
  parameter logic [NUM_DEST-1:0]        VC_LIST   = '0,
  localparam int                        FLIT_W    = flit_w(DATA_W, DEST_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int IDX_W     = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam int VALID_BIT = valid_bit(DATA_W, DEST_W);
  localparam int MARK_BIT  = mark_bit(DATA_W, DEST_W);
  localparam int DEST_LSB  = dest_lsb(DATA_W);
  localparam int VC_BIT    = vc_bit(DATA_W);

  state_e            state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] result;
  logic              usable;
  logic              pair_done;
  logic [DATA_W-1:0] pair_result;
  logic [DEST_W-1:0] unused_in_dest;

  // The incoming dest field addressed this PE; nothing downstream needs it.
  assign unused_in_dest = in_flit[DEST_LSB +: DEST_W];

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);

  // Malformed flits are still consumed; they simply never reach the collector.
  assign usable = in_valid & in_ready & in_flit[VALID_BIT] & in_flit[MARK_BIT];

  xor_operand_collector #(
    .DATA_W (DATA_W),
    .MODE   (MODE),
    .KEY    (KEY)
  ) u_collector (
    .clk         (clk),
    .rst         (rst),
    .load        (usable),
    .tag         (in_flit[VC_BIT]),
    .data        (in_flit[DATA_W-1:0]),
    .pair_done   (pair_done),
    .pair_result (pair_result)
  );

  // Decoded purely from registered state, so out_flit has no path from in_flit.
  assign out_flit = out_valid
                  ? {2'b11, DEST_LIST[int'(idx)*DEST_W +: DEST_W], VC_LIST[idx], result}
                  : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state  <= COLLECT;
      idx    <= '0;
      result <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (pair_done) begin
            result <= pair_result;
            idx    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx == IDX_W'(NUM_DEST - 1)) begin
              state <= COLLECT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_pe_mcast.sv
// Bench for xor_pe_mcast: a MODE 0 default instance, a MODE 1 three-way multicast
// instance, and a 32-bit MODE 1 instance, checked against a spec-level model.
module tb_xor_pe_mcast;
  import noc_pkg::*;

  localparam int FW  = 71;
  localparam int FW2 = 39;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [FW-1:0] in_flit   [2];
  logic [FW-1:0] out_flit  [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic          busy      [2];

  logic [FW2-1:0] n_in_flit, n_out_flit;
  logic           n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_busy;

  xor_pe_mcast u_mode0 (
    .clk(clk), .rst(rst),
    .in_flit(in_flit[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_flit(out_flit[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .busy(busy[0])
  );

  xor_pe_mcast #(
    .MODE(1), .NUM_DEST(3), .DEST_LIST({4'd9, 4'd5, 4'd3}), .VC_LIST(3'b010)
  ) u_mode1 (
    .clk(clk), .rst(rst),
    .in_flit(in_flit[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_flit(out_flit[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .busy(busy[1])
  );

  xor_pe_mcast #(.DATA_W(32), .MODE(1)) u_narrow (
    .clk(clk), .rst(rst),
    .in_flit(n_in_flit), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .out_flit(n_out_flit), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .busy(n_busy)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: per-instance mode, fan-out list, and pending operands.
  int         mode_of [2] = '{0, 1};
  int         nd      [2] = '{2, 3};
  logic [3:0] dl      [2][3] = '{'{4'd7, 4'd7, 4'd0}, '{4'd3, 4'd5, 4'd9}};
  logic       vl      [2][3] = '{'{1'b0, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0}};
  logic [63:0] ma [2], mb [2];
  bit          ha [2], hb [2];
  logic [FW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  function automatic logic [FW-1:0] mk_in(input logic v, input logic m, input logic tag,
                                          input logic [63:0] p);
    return {v, m, 4'h0, tag, p};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      ha[s] = 1'b0;
      hb[s] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic model_accept(input int sel, input logic [FW-1:0] f);
    logic [63:0] p;
    logic [63:0] res;
    bit          fire;
    p    = f[63:0];
    res  = '0;
    fire = 1'b0;
    if (f[FW-1] && f[FW-2]) begin
      if (mode_of[sel] == 0) begin
        if (!f[64]) begin
          fire = 1'b1;
          res  = p ^ 64'd4;
        end
      end else begin
        if (f[64]) begin mb[sel] = p; hb[sel] = 1'b1; end
        else       begin ma[sel] = p; ha[sel] = 1'b1; end
        if (ha[sel] && hb[sel]) begin
          fire    = 1'b1;
          res     = ma[sel] ^ mb[sel];
          ha[sel] = 1'b0;
          hb[sel] = 1'b0;
        end
      end
    end
    if (fire)
      for (int i = 0; i < nd[sel]; i++) exp_q.push_back({2'b11, dl[sel][i], vl[sel][i], res});
  endtask

  // pace: 0 = always ready, 1 = random stalls, 2 = stall 3 cycles on the second destination.
  task automatic drain(input int sel, input int pace, input bit junk);
    int   budget;
    int   sent;
    int   stall;
    logic rdy;
    budget = 64;
    sent   = 0;
    stall  = 0;
    while (exp_q.size() > 0 && budget > 0) begin
      check("out_valid", out_valid[sel], 1);
      check("out_flit", out_flit[sel], exp_q[0]);
      check("in_ready_send", in_ready[sel], 0);
      check("busy_send", busy[sel], 1);
      in_valid[sel] = junk && (budget == 64);
      in_flit[sel]  = (junk && budget == 64) ? mk_in(1, 1, 0, 64'h55) : '0;
      case (pace)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = !(sent == 1 && stall < 3);
      endcase
      if (!rdy) stall++;
      out_ready[sel] = rdy;
      @(negedge clk);
      if (rdy) begin
        void'(exp_q.pop_front());
        sent++;
      end
      budget--;
    end
    in_valid[sel]  = 1'b0;
    out_ready[sel] = 1'b1;
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    check("done_out_valid", out_valid[sel], 0);
    check("done_in_ready", in_ready[sel], 1);
    check("done_out_flit", out_flit[sel], 0);
    check("done_busy", busy[sel], 0);
  endtask

  task automatic offer(input int sel, input logic [FW-1:0] f, input int pace, input bit junk);
    @(negedge clk);
    check("idle_in_ready", in_ready[sel], 1);
    in_flit[sel]  = f;
    in_valid[sel] = 1'b1;
    @(negedge clk);
    in_valid[sel] = 1'b0;
    in_flit[sel]  = '0;
    model_accept(sel, f);
    if (exp_q.size() == 0) begin
      check("quiet_out_valid", out_valid[sel], 0);
      check("quiet_out_flit", out_flit[sel], 0);
      check("quiet_in_ready", in_ready[sel], 1);
    end else begin
      drain(sel, pace, junk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] f;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      in_flit[s]   = '0;
      in_valid[s]  = 1'b0;
      out_ready[s] = 1'b1;
    end
    n_in_flit   = '0;
    n_in_valid  = 1'b0;
    n_out_ready = 1'b1;
    model_reset();

    #12;
    check("rst_in_ready", in_ready[0], 1);
    check("rst_out_valid", out_valid[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_out_flit", out_flit[0], 0);
    check("rst_out_flit_m1", out_flit[1], 0);
    @(negedge clk);
    rst = 1'b0;

    // MODE 0 directed: payload 1 -> 0x5 to dest 0111 twice; a flit offered in SEND is ignored.
    offer(0, mk_in(1, 1, 0, 64'h1), 0, 1'b1);
    offer(0, mk_in(0, 1, 0, 64'h9), 0, 1'b0);
    offer(0, mk_in(1, 0, 0, 64'h9), 0, 1'b0);
    offer(0, mk_in(1, 1, 1, 64'h9), 0, 1'b0);

    // MODE 1 directed: F0^0F, then overwrite of A before B arrives.
    offer(1, mk_in(1, 1, 0, 64'hF0), 0, 1'b0);
    offer(1, mk_in(1, 1, 1, 64'h0F), 0, 1'b0);
    offer(1, mk_in(1, 1, 0, 64'h1), 0, 1'b0);
    offer(1, mk_in(1, 1, 0, 64'h3), 0, 1'b0);
    offer(1, mk_in(1, 1, 1, 64'h2), 0, 1'b0);

    // Backpressure held on the second destination.
    offer(1, mk_in(1, 1, 1, 64'hDEAD_BEEF), 0, 1'b0);
    offer(1, mk_in(1, 1, 0, 64'h1234_5678_9ABC_DEF0), 2, 1'b0);

    // Reset in SEND after the first destination has gone out.
    offer(1, mk_in(1, 1, 0, 64'hAA), 0, 1'b0);
    @(negedge clk);
    f = mk_in(1, 1, 1, 64'h55);
    in_flit[1]  = f;
    in_valid[1] = 1'b1;
    @(negedge clk);
    in_valid[1] = 1'b0;
    model_accept(1, f);
    check("rstsend_first", out_flit[1], exp_q[0]);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstsend_out_valid", out_valid[1], 0);
    check("rstsend_in_ready", in_ready[1], 1);
    check("rstsend_out_flit", out_flit[1], 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // A partial operand is discarded by reset.
    offer(1, mk_in(1, 1, 0, 64'h77), 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    offer(1, mk_in(1, 1, 1, 64'h0F0F), 0, 1'b0);
    offer(1, mk_in(1, 1, 0, 64'hFF00), 0, 1'b0);

    // Randomized traffic on both wide instances.
    for (int i = 0; i < 30; i++) begin
      f = mk_in($urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
                {$urandom, $urandom});
      offer(0, f, 1, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      f = mk_in($urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1,
                {$urandom, $urandom});
      offer(1, f, 1, 1'b0);
    end

    // 32-bit MODE 1: FFFF0000 ^ 0000FFFF, 39-bit flit layout.
    @(negedge clk);
    n_in_flit  = {1'b1, 1'b1, 4'h0, 1'b0, 32'hFFFF_0000};
    n_in_valid = 1'b1;
    @(negedge clk);
    check("narrow_a_only", n_out_valid, 0);
    n_in_flit = {1'b1, 1'b1, 4'h0, 1'b1, 32'h0000_FFFF};
    @(negedge clk);
    n_in_valid = 1'b0;
    check("narrow_flit0", n_out_flit, {1'b1, 1'b1, 4'b0111, 1'b0, 32'hFFFF_FFFF});
    check("narrow_valid_bit", n_out_flit[38], 1);
    check("narrow_mark_bit", n_out_flit[37], 1);
    check("narrow_dest", n_out_flit[36:33], 4'b0111);
    check("narrow_vc", n_out_flit[32], 0);
    @(negedge clk);
    check("narrow_flit1", n_out_flit, {1'b1, 1'b1, 4'b0111, 1'b0, 32'hFFFF_FFFF});
    @(negedge clk);
    check("narrow_done_valid", n_out_valid, 0);
    check("narrow_done_ready", n_in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/xor_pe_mcast.md
# xor_pe_mcast

Parametrised XOR processing element for the mesh NoC: sits behind a router local port, accepts single-flit packets, computes an XOR result, and multicasts the result flit to a parameter-defined list of destinations. It generalises the fixed single-operand XOR node to configurable data/destination width, a one- or two-operand mode, N-way multicast, and ready/valid backpressure on both sides.

## Interface
- DATA_W, 64, payload width
- DEST_W, 4, destination field width
- NUM_DEST, 2, multicast fan-out (≥1)
- MODE, 0, 0 = payload ^ KEY; 1 = operand A ^ operand B
- KEY, 64'd4, constant XOR operand for MODE 0
- DEST_LIST, {4'b0111,4'b0111}, packed NUM_DEST×DEST_W; entry i at [i*DEST_W +: DEST_W]
- VC_LIST, 2'b00, packed NUM_DEST×1; VC for entry i
- FLIT_W, DATA_W+DEST_W+3, derived, not overridden
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_flit  input  FLIT_W  flit from router
- in_valid  input  1  in_flit valid
- in_ready  output  1  block can accept in_flit
- out_flit  output  FLIT_W  result flit to router
- out_valid  output  1  out_flit valid
- out_ready  input  1  router accepts out_flit
- busy  output  1  high in SEND state

## Operation
- Flit fields: [FLIT_W-1] valid bit, [FLIT_W-2] single-flit marker, [FLIT_W-3 -: DEST_W] dest, [DATA_W] tag/VC, [DATA_W-1:0] payload.
- Transfer in: in_valid & in_ready on a clock edge. Flit used only if bits [FLIT_W-1] and [FLIT_W-2] are both 1; otherwise consumed and dropped, no state change.
- States: COLLECT, SEND.
- COLLECT: in_ready = 1, out_valid = 0.
  - MODE 0: usable flit with tag 0 → result = payload ^ KEY, idx = 0, go SEND. Tag 1 flits dropped.
  - MODE 1: tag 0 loads A and sets have_a; tag 1 loads B and sets have_b. Repeat tag before pair is complete overwrites (latest wins). When both flags are set (including on the edge that sets the second) → result = A ^ B, clear both flags, idx = 0, go SEND.
- SEND: in_ready = 0, out_valid = 1, busy = 1, out_flit = {1'b1, 1'b1, DEST_LIST[idx], VC_LIST[idx], result}.
  - On out_valid & out_ready: if idx == NUM_DEST-1 → COLLECT, else idx+1.
- Arithmetic: bitwise XOR, DATA_W wide, no carry. idx width $clog2(NUM_DEST) (min 1); never exceeds NUM_DEST-1.

## Timing
- Reset (async assert, sync-released use on next edge): state COLLECT, in_ready = 1, out_valid = 0, busy = 0, out_flit = 0, have_a = have_b = 0, idx = 0, result = 0.
- Latency: completing flit accepted at edge k → out_valid = 1 from edge k (visible cycle k+1); first result transfer possible at edge k+1.
- NUM_DEST flits leave in NUM_DEST back-to-back cycles with out_ready held high; total occupancy NUM_DEST cycles, then in_ready = 1 the next cycle.
- Backpressure: while out_valid & !out_ready, out_flit and idx stay stable.
- out_flit = 0 whenever out_valid = 0.
- All outputs registered or decoded from state only; no combinational in→out path.
- rst asserted mid-SEND: out_valid drops immediately (async); remaining destinations abandoned; partial operands discarded.

## Structure
- noc_pkg: flit field offset functions/localparams (VALID_BIT, MARK_BIT, DEST_LSB, VC_BIT), flit_w(DATA_W, DEST_W) function, state enum {COLLECT, SEND}.
- One sub-module natural: xor_operand_collector (A/B registers, have flags, tag decode, pair-complete strobe); top holds FSM, idx counter, flit packing.

## Test plan
- MODE 0, defaults: in_flit valid/marker set, tag 0, payload 0x1 → two flits {1,1,0111,0,0x5} on consecutive cycles, then in_ready = 1.
- MODE 1: A = 0xF0 (tag 0), then B = 0x0F (tag 1) → result 0xFF sent to each DEST_LIST entry; A = 0x1, A = 0x3, B = 0x2 → result 0x1 (overwrite).
- Backpressure, NUM_DEST = 3, DEST_LIST = {3,5,9}: hold out_ready low 3 cycles on idx 1 → out_flit dest 5 stable throughout; order 3,5,9 preserved.
- Flits with marker bit 0 or valid bit 0, and in MODE 0 tag-1 flits → no output, state unchanged; flits offered in SEND see in_ready = 0.
- Reset asserted during SEND after first destination sent → out_valid = 0 same cycle, in_ready = 1; next operand starts clean (no stale have_a).
- MODE 1 with DATA_W = 32: A = 0xFFFF_0000, B = 0x0000_FFFF → result 0xFFFF_FFFF; FLIT_W = 39, fields at correct offsets.
